// File: rtl/stage5_control_unit.sv
// Multi-cycle control FSM for the stage 5 stack datapath: fetches into IR, decodes IR[15:12]
// and sequences PC, stack-pointer, memory and register strobes one state per cycle.
module stage5_control_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] IRIn,
  input  logic [15:0] ValAIn,
  output logic        MSPWrite,
  output logic        MSPPop,
  output logic        MSPRegReset,
  output logic        RSPWrite,
  output logic        RSPPop,
  output logic        RSPRegReset,
  output logic        PCWrite,
  output logic        PCSource,
  output logic        PCAdd,
  output logic        ValAWrite,
  output logic        ValBWrite,
  output logic        IRWrite,
  output logic        MemRead1,
  output logic        MemRead2,
  output logic        MemWrite1,
  output logic        MemWrite2,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic [2:0]  MemData,
  output logic [1:0]  AluOp,
  output logic        Halted,
  output logic        Illegal,
  output logic [3:0]  State
);

  // Seventeen states need five bits; HALT lives above the 4-bit debug range and
  // shows as 0 on State, so Halted is what tells it apart from RST.
  localparam logic [4:0] S_RST    = 5'h00;
  localparam logic [4:0] S_FETCH  = 5'h01;
  localparam logic [4:0] S_DECODE = 5'h02;
  localparam logic [4:0] S_PUSH   = 5'h03;
  localparam logic [4:0] S_A_POP  = 5'h04;
  localparam logic [4:0] S_A_RDB  = 5'h05;
  localparam logic [4:0] S_A_RDA  = 5'h06;
  localparam logic [4:0] S_A_WB   = 5'h07;
  localparam logic [4:0] S_JMP    = 5'h08;
  localparam logic [4:0] S_B_POP  = 5'h09;
  localparam logic [4:0] S_B_RD   = 5'h0A;
  localparam logic [4:0] S_B_TEST = 5'h0B;
  localparam logic [4:0] S_CALL   = 5'h0C;
  localparam logic [4:0] S_R_POP  = 5'h0D;
  localparam logic [4:0] S_R_RD   = 5'h0E;
  localparam logic [4:0] S_R_JMP  = 5'h0F;
  localparam logic [4:0] S_HALT   = 5'h10;

  logic [4:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       unused_ir;

  assign unused_ir = ^IRIn[11:2];
  assign AluOp     = IRIn[1:0];
  assign Illegal   = illegal_q;
  assign State     = state_q[3:0];
  assign MemWrite1 = 1'b0;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (IRIn[15:12])
          4'h0:    state_d = S_FETCH;
          4'h1:    state_d = S_PUSH;
          4'h2:    state_d = S_A_POP;
          4'h3:    state_d = S_JMP;
          4'h4:    state_d = S_B_POP;
          4'h5:    state_d = S_CALL;
          4'h6:    state_d = S_R_POP;
          4'hF:    state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_PUSH:   state_d = S_FETCH;
      S_A_POP:  state_d = S_A_RDB;
      S_A_RDB:  state_d = S_A_RDA;
      S_A_RDA:  state_d = S_A_WB;
      S_A_WB:   state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
      S_B_POP:  state_d = S_B_RD;
      S_B_RD:   state_d = S_B_TEST;
      S_B_TEST: state_d = S_FETCH;
      S_CALL:   state_d = S_FETCH;
      S_R_POP:  state_d = S_R_RD;
      S_R_RD:   state_d = S_R_JMP;
      S_R_JMP:  state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RST;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are Moore on state_q, but forced quiet while Reset is held so an
  // abandoned instruction cannot leak a write in the reset cycle.
  always_comb begin
    MSPWrite    = 1'b0;
    MSPPop      = 1'b0;
    MSPRegReset = 1'b0;
    RSPWrite    = 1'b0;
    RSPPop      = 1'b0;
    RSPRegReset = 1'b0;
    PCWrite     = 1'b0;
    PCSource    = 1'b0;
    PCAdd       = 1'b0;
    ValAWrite   = 1'b0;
    ValBWrite   = 1'b0;
    IRWrite     = 1'b0;
    MemRead1    = 1'b0;
    MemRead2    = 1'b0;
    MemWrite2   = 1'b0;
    MemDst1     = 2'd0;
    MemDst2     = 2'd0;
    MemData     = 3'd0;
    Halted      = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_RST: begin
          MSPRegReset = 1'b1;
          RSPRegReset = 1'b1;
        end
        S_FETCH: begin
          MemRead1 = 1'b1;
          IRWrite  = 1'b1;
          PCWrite  = 1'b1;
        end
        S_PUSH: begin
          MemWrite2 = 1'b1;
          MemData   = 3'd2;
          MSPWrite  = 1'b1;
        end
        S_A_POP, S_B_POP: begin
          MSPWrite = 1'b1;
          MSPPop   = 1'b1;
        end
        S_A_RDB: begin
          MemRead2  = 1'b1;
          ValBWrite = 1'b1;
          MSPWrite  = 1'b1;
          MSPPop    = 1'b1;
        end
        S_A_RDA, S_B_RD: begin
          MemRead1  = 1'b1;
          MemDst1   = 2'd1;
          ValAWrite = 1'b1;
        end
        S_A_WB: begin
          MemWrite2 = 1'b1;
          MemData   = 3'd1;
          MSPWrite  = 1'b1;
        end
        S_JMP: begin
          PCWrite = 1'b1;
          PCAdd   = 1'b1;
        end
        S_B_TEST: begin
          PCWrite = (ValAIn == 16'h0000);
          PCAdd   = (ValAIn == 16'h0000);
        end
        // Return address is the already-incremented PC, stored before this edge updates it.
        S_CALL: begin
          MemWrite2 = 1'b1;
          MemDst2   = 2'd1;
          RSPWrite  = 1'b1;
          PCWrite   = 1'b1;
          PCAdd     = 1'b1;
        end
        S_R_POP: begin
          RSPWrite = 1'b1;
          RSPPop   = 1'b1;
        end
        S_R_RD: begin
          MemRead2  = 1'b1;
          MemDst2   = 2'd1;
          ValAWrite = 1'b1;
        end
        S_R_JMP: begin
          PCWrite  = 1'b1;
          PCSource = 1'b1;
        end
        S_HALT:   Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage5_control_unit.sv
// Directed bench for stage5_control_unit: walks each opcode through its state sequence
// and compares the packed strobe bus every cycle against hand-derived patterns.
module tb_stage5_control_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] IRIn;
  logic [15:0] ValAIn;
  logic        MSPWrite, MSPPop, MSPRegReset, RSPWrite, RSPPop, RSPRegReset;
  logic        PCWrite, PCSource, PCAdd, ValAWrite, ValBWrite, IRWrite;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0]  MemDst1, MemDst2, AluOp;
  logic [2:0]  MemData;
  logic        Halted, Illegal;
  logic [3:0]  State;

  int errors = 0;
  int checks = 0;

  stage5_control_unit dut (
    .CLK(CLK), .Reset(Reset), .IRIn(IRIn), .ValAIn(ValAIn),
    .MSPWrite(MSPWrite), .MSPPop(MSPPop), .MSPRegReset(MSPRegReset),
    .RSPWrite(RSPWrite), .RSPPop(RSPPop), .RSPRegReset(RSPRegReset),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
    .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
    .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData), .AluOp(AluOp),
    .Halted(Halted), .Illegal(Illegal), .State(State)
  );

  always #5 CLK = ~CLK;

  logic [23:0] strobes;
  assign strobes = {MSPWrite, MSPPop, MSPRegReset, RSPWrite, RSPPop, RSPRegReset,
                    PCWrite, PCSource, PCAdd, ValAWrite, ValBWrite, IRWrite,
                    MemRead1, MemRead2, MemWrite1, MemWrite2, MemDst1, MemDst2, MemData, Halted};

  localparam logic [23:0] MSPW = 24'h800000, MSPP = 24'h400000, MSPR = 24'h200000;
  localparam logic [23:0] RSPW = 24'h100000, RSPP = 24'h080000, RSPR = 24'h040000;
  localparam logic [23:0] PCW  = 24'h020000, PCS  = 24'h010000, PCA  = 24'h008000;
  localparam logic [23:0] VAW  = 24'h004000, VBW  = 24'h002000, IRW  = 24'h001000;
  localparam logic [23:0] MR1  = 24'h000800, MR2  = 24'h000400, MW2  = 24'h000100;
  localparam logic [23:0] D1_MSP = 24'h000040, D2_RSP = 24'h000010;
  localparam logic [23:0] MD_RES = 24'h000002, MD_IMM = 24'h000004, HLT = 24'h000001;

  localparam logic [23:0] E_RST   = MSPR | RSPR;
  localparam logic [23:0] E_FETCH = MR1 | IRW | PCW;
  localparam logic [23:0] E_DEC   = 24'h0;
  localparam logic [23:0] E_PUSH  = MW2 | MD_IMM | MSPW;
  localparam logic [23:0] E_POP   = MSPW | MSPP;
  localparam logic [23:0] E_ARDB  = MR2 | VBW | MSPW | MSPP;
  localparam logic [23:0] E_RDA   = MR1 | D1_MSP | VAW;
  localparam logic [23:0] E_AWB   = MW2 | MD_RES | MSPW;
  localparam logic [23:0] E_JMP   = PCW | PCA;
  localparam logic [23:0] E_CALL  = MW2 | D2_RSP | RSPW | PCW | PCA;
  localparam logic [23:0] E_RPOP  = RSPW | RSPP;
  localparam logic [23:0] E_RRD   = MR2 | D2_RSP | VAW;
  localparam logic [23:0] E_RJMP  = PCW | PCS;
  localparam logic [23:0] E_HALT  = HLT;
  localparam logic [3:0]  ST_RST  = 4'h0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; IRIn = 16'h0000; ValAIn = 16'h0000;
    step();
    checks++;
    if (strobes !== 24'h0) begin
      $display("FAIL reset_held strobes got %h want %h", strobes, 24'h0); errors++;
    end
    step();
    Reset = 1'b0;
    #1;
    checks++;
    if (State !== ST_RST || strobes !== E_RST || Illegal !== 1'b0) begin
      $display("FAIL reset_rst state=%h strobes=%h illegal=%b want state=%h strobes=%h illegal=0",
               State, strobes, Illegal, ST_RST, E_RST); errors++;
    end
    step();
    checks++;
    if (strobes !== E_FETCH) begin
      $display("FAIL reset_fetch strobes got %h want %h", strobes, E_FETCH); errors++;
    end
    $display("reset: released, RST then FETCH");
  endtask

  task automatic test_nop();
    logic [23:0] want [3];
    want = '{E_FETCH, E_DEC, E_FETCH};
    IRIn = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (strobes !== want[i]) begin
        $display("FAIL nop cyc%0d strobes got %h want %h", i, strobes, want[i]); errors++;
      end
      if (i < 2) step();
    end
    $display("nop: IR=%h", IRIn);
  endtask

  task automatic test_pushi();
    logic [23:0] want [4];
    want = '{E_FETCH, E_DEC, E_PUSH, E_FETCH};
    IRIn = 16'h1ABC;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (strobes !== want[i]) begin
        $display("FAIL pushi cyc%0d strobes got %h want %h", i, strobes, want[i]); errors++;
      end
      if (i < 3) step();
    end
    $display("pushi: IR=%h", IRIn);
  endtask

  task automatic test_alu(input logic [15:0] ir, input logic [1:0] op);
    logic [23:0] want [7];
    want = '{E_FETCH, E_DEC, E_POP, E_ARDB, E_RDA, E_AWB, E_FETCH};
    IRIn = ir;
    #1;
    checks++;
    if (AluOp !== op) begin
      $display("FAIL alu_op got %0d want %0d", AluOp, op); errors++;
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (strobes !== want[i]) begin
        $display("FAIL alu cyc%0d strobes got %h want %h", i, strobes, want[i]); errors++;
      end
      if (i < 6) step();
    end
    $display("alu: IR=%h", IRIn);
  endtask

  task automatic test_jmp();
    logic [23:0] want [4];
    want = '{E_FETCH, E_DEC, E_JMP, E_FETCH};
    IRIn = 16'h3005;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (strobes !== want[i]) begin
        $display("FAIL jmp cyc%0d strobes got %h want %h", i, strobes, want[i]); errors++;
      end
      if (i < 3) step();
    end
    $display("jmp: IR=%h", IRIn);
  endtask

  task automatic test_brz(input logic [15:0] va, input logic [23:0] e_test);
    logic [23:0] want [6];
    want = '{E_FETCH, E_DEC, E_POP, E_RDA, e_test, E_FETCH};
    IRIn = 16'h4000;
    ValAIn = va;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (strobes !== want[i]) begin
        $display("FAIL brz va=%h cyc%0d strobes got %h want %h", va, i, strobes, want[i]); errors++;
      end
      if (i < 5) step();
    end
    $display("brz: ValA=%h", va);
  endtask

  task automatic test_call_ret();
    logic [23:0] want_c [4];
    logic [23:0] want_r [6];
    want_c = '{E_FETCH, E_DEC, E_CALL, E_FETCH};
    want_r = '{E_FETCH, E_DEC, E_RPOP, E_RRD, E_RJMP, E_FETCH};
    IRIn = 16'h5010;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (strobes !== want_c[i]) begin
        $display("FAIL call cyc%0d strobes got %h want %h", i, strobes, want_c[i]); errors++;
      end
      if (i < 3) step();
    end
    $display("call: IR=%h", IRIn);
    IRIn = 16'h6000;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (strobes !== want_r[i]) begin
        $display("FAIL ret cyc%0d strobes got %h want %h", i, strobes, want_r[i]); errors++;
      end
      if (i < 5) step();
    end
    $display("ret: IR=%h", IRIn);
  endtask

  task automatic test_illegal();
    IRIn = 16'h8000;
    step();
    checks++;
    if (strobes !== E_DEC || Illegal !== 1'b0) begin
      $display("FAIL illegal_decode strobes=%h illegal=%b want %h illegal=0", strobes, Illegal, E_DEC);
      errors++;
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (strobes !== E_HALT || Illegal !== 1'b1) begin
        $display("FAIL illegal_halt cyc%0d strobes=%h illegal=%b want %h illegal=1",
                 i, strobes, Illegal, E_HALT); errors++;
      end
    end
    $display("illegal: IR=%h halted", IRIn);
  endtask

  task automatic test_reset_recover();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    checks++;
    if (State !== ST_RST || strobes !== E_RST || Illegal !== 1'b0) begin
      $display("FAIL recover_rst state=%h strobes=%h illegal=%b want state=%h strobes=%h illegal=0",
               State, strobes, Illegal, ST_RST, E_RST); errors++;
    end
    step();
    checks++;
    if (strobes !== E_FETCH) begin
      $display("FAIL recover_fetch strobes got %h want %h", strobes, E_FETCH); errors++;
    end
    $display("recover: reset leaves HALT");
  endtask

  task automatic test_midreset();
    IRIn = 16'h2003;
    step(); step(); step();
    checks++;
    if (strobes !== E_ARDB) begin
      $display("FAIL mid_ardb strobes got %h want %h", strobes, E_ARDB); errors++;
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (strobes !== 24'h0) begin
      $display("FAIL mid_gated strobes got %h want %h", strobes, 24'h0); errors++;
    end
    step();
    checks++;
    if (State !== ST_RST || Illegal !== 1'b0 || strobes !== 24'h0) begin
      $display("FAIL mid_rst state=%h illegal=%b strobes=%h want state=%h illegal=0 strobes=0",
               State, Illegal, strobes, ST_RST); errors++;
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (strobes !== E_RST) begin
      $display("FAIL mid_rst_out strobes got %h want %h", strobes, E_RST); errors++;
    end
    step();
    checks++;
    if (strobes !== E_FETCH) begin
      $display("FAIL mid_fetch strobes got %h want %h", strobes, E_FETCH); errors++;
    end
    $display("midreset: ALU abandoned in A_RDB");
  endtask

  initial begin
    test_reset();
    test_nop();
    test_pushi();
    test_alu(16'h2001, 2'd1);
    test_jmp();
    test_brz(16'h0000, E_JMP);
    test_brz(16'h0001, 24'h0);
    test_call_ret();
    test_nop();
    test_illegal();
    test_reset_recover();
    test_midreset();
    test_alu(16'h2002, 2'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage5_control_unit.md
# stage5_control_unit

Multi-cycle control FSM for the stage 5 datapath: PC, main stack pointer (MSP), return stack pointer (RSP), dual-port memory, and the ValA, ValB and IR registers. It fetches a 16-bit instruction into IR and decodes IR[15:12]. It then drives every datapath control strobe, one state per cycle, until the instruction retires. It sits beside the stage 5 datapath; the ALU producing ResOut is external and receives AluOp.

## Interface
- No parameters.
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- IRIn  in  16  current IR register value.
- ValAIn  in  16  current ValA register value.
- MSPWrite, MSPPop, MSPRegReset  out  1 each  MSP controls.
- RSPWrite, RSPPop, RSPRegReset  out  1 each  RSP controls.
- PCWrite, PCSource, PCAdd  out  1 each  PC controls.
  - PCSource: 0 = adder, 1 = ValA.
  - PCAdd: 0 = +1, 1 = +SignExt.
- ValAWrite, ValBWrite, IRWrite  out  1 each  register load enables.
- MemRead1, MemRead2, MemWrite1, MemWrite2  out  1 each  memory port strobes.
- MemDst1  out  2  port 1 address select: 0 = PC, 1 = MSP.
- MemDst2  out  2  port 2 address select: 0 = MSP, 1 = RSP.
- MemData  out  3  write-data select: 0 = PC, 1 = ResOut, 2 = ZeroExt imm.
- AluOp  out  2  equals IRIn[1:0], combinational.
- Halted  out  1  high in HALT state.
- Illegal  out  1  sticky; set on an undefined opcode, cleared only by Reset.
- State  out  4  current state encoding, for debug.

## Operation
- Stack convention: the pointer addresses the next free slot.
  - Push: write at the pointer, with Write=1 and Pop=0 in the same cycle.
  - Pop: one cycle with Write=1 and Pop=1, then read at the new pointer.
- Every strobe not listed for a state is 0; selects not listed are 0.
- States: RST, FETCH, DECODE, PUSH, A_POP, A_RDB, A_RDA, A_WB, JMP, B_POP, B_RD, B_TEST, CALL, R_POP, R_RD, R_JMP, HALT.
- RST: MSPRegReset=RSPRegReset=1; go to FETCH.
- FETCH: MemRead1, MemDst1=0, IRWrite, PCWrite (PCAdd=0); go to DECODE.
- DECODE: no strobes; dispatch on IRIn[15:12]:
  - 0x0 NOP → FETCH.
  - 0x1 PUSHI → PUSH.
  - 0x2 ALU → A_POP.
  - 0x3 JMP → JMP.
  - 0x4 BRZ → B_POP.
  - 0x5 CALL → CALL.
  - 0x6 RET → R_POP.
  - 0xF HALT → HALT.
  - Any other opcode: set Illegal, → HALT.
- PUSH: MemWrite2, MemDst2=0, MemData=2, MSPWrite (MSPPop=0); → FETCH.
- A_POP: MSPWrite, MSPPop=1.
- A_RDB: MemRead2, MemDst2=0, ValBWrite, MSPWrite, MSPPop=1.
- A_RDA: MemRead1, MemDst1=1, ValAWrite.
- A_WB: MemWrite2, MemDst2=0, MemData=1, MSPWrite (MSPPop=0); → FETCH.
- JMP: PCWrite, PCAdd=1; → FETCH. The offset is relative to the already-incremented PC.
- B_POP: MSPWrite, MSPPop=1.
- B_RD: MemRead1, MemDst1=1, ValAWrite.
- B_TEST: if ValAIn==16'h0000, PCWrite with PCAdd=1; else no strobes; → FETCH.
- CALL: in one cycle, MemWrite2, MemDst2=1, MemData=0, RSPWrite (RSPPop=0), PCWrite, PCAdd=1.
  - Memory captures the pre-edge PC, i.e. the return address.
- R_POP: RSPWrite, RSPPop=1.
- R_RD: MemRead2, MemDst2=1, ValAWrite.
- R_JMP: PCWrite, PCSource=1; → FETCH.
- HALT: no strobes, Halted=1; exit only via Reset.
- No state ever asserts MemWrite1.
- Never assert more than one of MemRead1/MemWrite1 per cycle, nor more than one of MemRead2/MemWrite2.

## Timing
- Reset sampled high at any edge, including mid-instruction:
  - next state RST;
  - the in-flight instruction is abandoned, with no further strobes;
  - Illegal cleared.
- While Reset is high, all strobes are 0. MSPRegReset/RSPRegReset are 1 only in the cycle the FSM is in RST.
- After Reset deasserts: RST (1 cycle), then FETCH. The PC reset value is owned by the PC module.
- Latency in cycles, FETCH included:

  | Instruction | Cycles |
  |---|---|
  | NOP | 2 |
  | PUSHI | 3 |
  | JMP | 3 |
  | CALL | 3 |
  | RET | 5 |
  | BRZ (taken or not) | 5 |
  | ALU | 6 |

- All outputs except AluOp decode from registered state only (Moore). The B_TEST PCWrite also depends on ValAIn.
- ValAIn in B_TEST reflects the value loaded at the end of B_RD.

## Test plan
- Reset held 2 cycles, then released → State=RST with both RegResets=1 for one cycle; next cycle FETCH with MemRead1=1, IRWrite=1, PCWrite=1, PCAdd=0.
- IRIn=16'h1ABC after FETCH → DECODE, then PUSH with MemWrite2=1, MemData=2, MSPWrite=1, MSPPop=0; FETCH again 3 cycles after the first FETCH.
- IRIn=16'h2001 → AluOp=1; A_POP/A_RDB/A_RDA/A_WB strobes exactly as specified; A_WB has MemData=1; 6 cycles total.
- IRIn=16'h4000, two runs:
  - ValAIn=0 in B_TEST → PCWrite=1, PCAdd=1.
  - ValAIn=16'h0001 → PCWrite=0.
  - Both return to FETCH.
- IRIn=16'h5010 then 16'h6000:
  - CALL cycle asserts MemWrite2, MemDst2=1, MemData=0, RSPWrite, PCWrite, PCAdd together.
  - RET ends in R_JMP with PCSource=1.
- IRIn=16'h8000 → Illegal=1, Halted=1, zero strobes for 10 cycles; Reset asserted in A_RDB of a later ALU op → RST next cycle, Illegal=0.
